byte_serializer: RTL and testbench
==================================

BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits (range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = transmit bit WIDTH-1 first, 0 = transmit bit 0 first.
REQ-003 SHALL have port clk, input, 1, rising-edge system clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_data, input, WIDTH, parallel word to serialize.
REQ-006 SHALL have port in_valid, input, 1, in_data valid this cycle.
REQ-007 SHALL have port in_ready, output, 1, holding register can accept a word.
REQ-008 SHALL have port en, input, 1, shift enable; 0 stalls the shifter.
REQ-009 SHALL have port out_bit, output, 1, serial data bit that drives the downstream sequence detector's din.
REQ-010 SHALL have port out_valid, output, 1, out_bit carries a payload bit this cycle.
REQ-011 SHALL have port out_last, output, 1, out_bit is the final bit of the current word.

Function
REQ-012 SHALL contain a one-word holding register (hold, hold_valid), a WIDTH-bit shift register, a bit counter of ceil(log2(WIDTH)) bits, and a two-state FSM: IDLE, SHIFT.
REQ-013 SHALL drive in_ready = ~hold_valid combinationally from the register, with no dependency on in_valid.
REQ-014 SHALL, at a rising edge with in_valid & in_ready, capture in_data into hold and set hold_valid, irrespective of en.
REQ-015 SHALL define load_evt = en & hold_valid & (state==IDLE | (state==SHIFT & cnt==WIDTH-1)).
REQ-016 SHALL, on load_evt, copy hold into the shifter, clear cnt to 0, enter SHIFT, and clear hold_valid in the same edge.
REQ-017 SHALL, in SHIFT with en=1 and cnt<WIDTH-1, shift one position toward the output end and increment cnt.
REQ-018 SHALL, in SHIFT with en=1, cnt==WIDTH-1 and hold_valid=0, return to IDLE.
REQ-019 SHALL hold state, shifter and cnt unchanged on any edge with en=0.
REQ-020 SHALL drive out_valid = (state==SHIFT).
REQ-021 SHALL drive out_bit = shifter[WIDTH-1] when MSB_FIRST=1, shifter[0] when MSB_FIRST=0, gated to 0 whenever out_valid=0.
REQ-022 SHALL drive out_last = out_valid & (cnt==WIDTH-1).
REQ-023 SHALL present the first bit of a word accepted at edge N during the cycle after edge N+1 when the FSM is IDLE and en=1 (2-edge latency).
REQ-024 SHALL stream consecutive words with no gap cycle when the next word is in hold by the edge ending the out_last cycle.
REQ-025 SHALL, because in_ready=0 whenever hold_valid=1, never accept and load-out the holding register from the same word at the same edge; the capture and the clearing of hold_valid shall not conflict.
REQ-026 SHALL keep each out_bit value stable for the whole of every cycle in which en=0.

Reset
REQ-027 SHALL, on rst=1, immediately (asynchronously) force state=IDLE, hold_valid=0, cnt=0 and shifter=0.
REQ-028 SHALL give the outputs these values under reset: in_ready=1, out_valid=0, out_last=0, out_bit=0.
REQ-029 SHALL, on rst assertion mid-word, discard the partial word and the held word, with no further bits emitted.
REQ-030 SHALL ignore in_valid on the first edge after rst deasserts only if rst is still high at that edge.

Verification
REQ-031 SHALL check: MSB_FIRST=1, en=1, send 8'hAA -> out_bit 1,0,1,0,1,0,1,0 on 8 consecutive valid cycles, with out_last on the 8th cycle; a downstream mealy 1010 detector pulses at bits 4 and 8.
REQ-032 SHALL check: two words 8'hF0 then 8'h0F offered back-to-back -> 16 contiguous out_valid cycles with bits 11110000 00001111, and in_ready low from capture until load.
REQ-033 SHALL check: en=0 for 3 cycles after the 3rd bit of 8'hC5 -> out_bit holds 0 for those cycles, and the full sequence 1,1,0,0,0,1,0,1 completes with no bit lost or repeated.
REQ-034 SHALL check: rst pulse during the 5th bit of 8'hFF with 8'h55 held -> out_valid=0 and in_ready=1 immediately, and no further bits of either word appear.
REQ-035 SHALL check: MSB_FIRST=0, send 8'h01 -> out_bit 1,0,0,0,0,0,0,0.
REQ-036 SHALL check: in_valid held high with no word accepted while hold_valid=1 -> the word is accepted only on the edge where in_ready=1, and each word is transmitted exactly once.

Source files
------------

// File: rtl/byte_serializer_if.sv
// byte_serializer_if: word-in / bit-out handshake bundle for byte_serializer.
interface byte_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             en;
    logic             out_bit;
    logic             out_valid;
    logic             out_last;
    modport master (output in_data, in_valid, en, input in_ready, out_bit, out_valid, out_last);
    modport slave  (input in_data, in_valid, en, output in_ready, out_bit, out_valid, out_last);
endinterface

// File: rtl/byte_serializer.sv
// byte_serializer: one-word holding register feeding a parallel-to-serial shifter with stall enable.
module byte_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input logic               clk,
    input logic               rst,
    byte_serializer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] hold;
    logic             hold_valid;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;
    logic             cnt_last;
    logic             capture;
    logic             load_evt;

    always_comb begin
        cnt_last = cnt == LAST;
        capture  = bus.in_valid & ~hold_valid;
        load_evt = bus.en & hold_valid & ((state == IDLE) | ((state == SHIFT) & cnt_last));
        shifted  = (MSB_FIRST != 0) ? {shifter[WIDTH-2:0], 1'b0} : {1'b0, shifter[WIDTH-1:1]};
    end

    assign bus.in_ready  = ~hold_valid;
    assign bus.out_valid = state == SHIFT;
    assign bus.out_bit   = bus.out_valid & ((MSB_FIRST != 0) ? shifter[WIDTH-1] : shifter[0]);
    assign bus.out_last  = bus.out_valid & cnt_last;

    // capture needs an empty hold and load needs a full one, so they never collide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            shifter    <= '0;
            cnt        <= '0;
        end else begin
            if (capture) hold <= bus.in_data;
            hold_valid <= capture | (hold_valid & ~load_evt);
            if (load_evt) begin
                shifter <= hold;
                cnt     <= '0;
                state   <= SHIFT;
            end else if (bus.en && state == SHIFT) begin
                if (cnt_last) state <= IDLE;
                else begin
                    shifter <= shifted;
                    cnt     <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: MSB- and LSB-first instances checked every cycle against a word-queue model.
module tb_byte_serializer;
    logic clk, rst, en, in_valid;
    logic [7:0] in_data;
    int checks = 0, errors = 0;

    byte_serializer_if #(.WIDTH(8)) bm ();
    byte_serializer_if #(.WIDTH(8)) bl ();
    assign bm.in_data = in_data;
    assign bm.in_valid = in_valid;
    assign bm.en = en;
    assign bl.in_data = in_data;
    assign bl.in_valid = in_valid;
    assign bl.en = en;

    byte_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (.clk(clk), .rst(rst), .bus(bm));
    byte_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (.clk(clk), .rst(rst), .bus(bl));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    // model: queue of accepted words, idx = bits of the head word already consumed
    logic [7:0] q[$];
    int idx = 0, cyc = 0, acc_cyc = 0, n_acc = 0, lasts_m = 0, lasts_l = 0;
    bit mv = 0, acc = 0, exp_ready, pend;
    logic [7:0] w;
    bit collecting = 0;
    logic [15:0] colm, coll;
    int ncol, lastpos, first_cyc, last_cyc, stall_seen;
    logic stall_or;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            idx = 0;
            mv = 0;
            chk("rst_ready", bm.in_ready, 1);
            chk("rst_valid", bm.out_valid | bl.out_valid, 0);
            chk("rst_last", bm.out_last | bl.out_last, 0);
            chk("rst_bit", bm.out_bit | bl.out_bit, 0);
        end else begin
            exp_ready = q.size() == (mv ? 1 : 0);
            w = mv ? q[0] : 8'h00;
            chk("ready_m", bm.in_ready, exp_ready);
            chk("ready_l", bl.in_ready, exp_ready);
            chk("valid_m", bm.out_valid, mv);
            chk("valid_l", bl.out_valid, mv);
            chk("bit_m", bm.out_bit, mv ? w[7-idx] : 1'b0);
            chk("bit_l", bl.out_bit, mv ? w[idx] : 1'b0);
            chk("last_m", bm.out_last, mv && idx == 7);
            chk("last_l", bl.out_last, mv && idx == 7);
            if (en && bm.out_valid && bm.out_last) lasts_m++;
            if (en && bl.out_valid && bl.out_last) lasts_l++;
            if (collecting && bm.out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (en) begin
                    colm = {colm[14:0], bm.out_bit};
                    coll = {coll[14:0], bl.out_bit};
                    ncol++;
                    if (bm.out_last) lastpos = ncol;
                end else begin
                    stall_seen++;
                    stall_or = stall_or | bm.out_bit;
                end
            end
            if (en && mv) begin
                idx++;
                if (idx == 8) begin
                    void'(q.pop_front());
                    idx = 0;
                end
            end
            pend = q.size() != 0;
            if (in_valid && exp_ready) begin
                q.push_back(in_data);
                acc = 1;
                acc_cyc = cyc;
                n_acc++;
            end
            if (en) mv = pend;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_col();
        colm = 0; coll = 0; ncol = 0; lastpos = -1;
        first_cyc = -1; last_cyc = -1; stall_seen = 0; stall_or = 0;
        collecting = 1;
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        in_valid = 1;
        in_data = d;
        acc = 0;
        while (!acc && n < 100) begin
            tick();
            n++;
        end
        if (!acc) chk("send_timeout", 1, 0);
        in_valid = 0;
        acc = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || mv) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        logic [3:0] h;
        logic [7:0] det;
        logic b;
        int n;
        rst = 1; en = 0; in_valid = 1; in_data = 8'h3C;
        repeat (3) tick();
        chk("reset_ready", bm.in_ready, 1);
        chk("reset_valid", bm.out_valid, 0);
        in_valid = 0;
        rst = 0;
        en = 1;
        tick();

        clear_col();
        send(8'hAA);
        wait_idle();
        chk("aa_msb", colm[7:0], 8'hAA);
        chk("aa_lsb", coll[7:0], 8'h55);
        chk("aa_count", ncol, 8);
        chk("aa_lastpos", lastpos, 8);
        chk("aa_latency", first_cyc - acc_cyc, 2);
        h = 0; det = 0;
        for (int i = 0; i < 8; i++) begin
            b = colm[7-i];
            h = {h[2:0], b};
            if (h == 4'b1010) begin
                det[i] = 1'b1;
                h = 0;
            end
        end
        chk("aa_detect", det, 8'h88);

        clear_col();
        send(8'hF0);
        send(8'h0F);
        wait_idle();
        chk("b2b_msb", colm, 16'hF00F);
        chk("b2b_lsb", coll, 16'h0FF0);
        chk("b2b_count", ncol, 16);
        chk("b2b_contig", last_cyc - first_cyc + 1, 16);

        clear_col();
        send(8'hC5);
        n = 0;
        for (int i = 0; i < 60 && (q.size() != 0 || mv); i++) begin
            if (ncol == 3 && n < 3) begin
                en = 0;
                n++;
            end else en = 1;
            tick();
        end
        en = 1;
        wait_idle();
        chk("stall_seq", colm[7:0], 8'hC5);
        chk("stall_count", ncol, 8);
        chk("stall_cycles", stall_seen, 3);
        chk("stall_bit", stall_or, 0);

        clear_col();
        send(8'hFF);
        send(8'h55);
        n = 0;
        while (ncol != 4 && n < 50) begin
            tick();
            n++;
        end
        if (ncol != 4) chk("rst_wait_timeout", ncol, 4);
        #1 rst = 1;
        #1;
        chk("async_valid", bm.out_valid | bl.out_valid, 0);
        chk("async_ready", bm.in_ready & bl.in_ready, 1);
        chk("async_bit", bm.out_bit | bl.out_bit, 0);
        tick();
        rst = 0;
        clear_col();
        repeat (20) tick();
        chk("post_rst_bits", ncol, 0);
        chk("post_rst_valid", first_cyc, -1);

        clear_col();
        send(8'h01);
        wait_idle();
        chk("one_msb", colm[7:0], 8'h01);
        chk("one_lsb", coll[7:0], 8'h80);
        collecting = 0;

        n_acc = 0; lasts_m = 0; lasts_l = 0;
        for (int i = 0; i < 3000; i++) begin
            en = $urandom_range(0, 3) != 0;
            if (!in_valid || acc) begin
                acc = 0;
                in_valid = $urandom_range(0, 2) != 0;
                in_data = 8'($urandom);
            end
            tick();
        end
        in_valid = 0;
        en = 1;
        tick();
        wait_idle();
        chk("rand_words_m", lasts_m, n_acc);
        chk("rand_words_l", lasts_l, n_acc);
        chk("rand_some", n_acc > 100, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
